instruction_sequencer: RTL

Multi-cycle fetch/execute controller for the image-downsampling processor. It owns the program counter and instruction register, fetches 16-bit words from instruction RAM, and presents them to the combinational instruction decoder. It qualifies the decoder's control strobes with a one-cycle execute enable. It stalls for DRAM read latency, DRAM write completion and UART transfers, and handles PC jumps and halt.

---
 rtl/proc_pkg.sv | 17 +
 rtl/latency_counter.sv | 17 +
 rtl/instruction_sequencer.sv | 94 +++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: shared sequencer states, opcode constants and default widths
package proc_pkg;
  localparam int PC_W_DEFAULT = 12;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD_IR,
    EXEC,
    DRAM_RD,
    DRAM_WR,
    UART_WAIT,
    HALT
  } state_e;
endpackage

// File: rtl/latency_counter.sv
// latency_counter: loadable down-counter that parks at zero and flags it
module latency_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = load_i ? val_i : (cnt_q == '0 ? cnt_q : cnt_q - W'(1));
  assign zero_o = cnt_q == '0;
  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: multi-cycle fetch/execute controller owning pc and ir,
// stalling for DRAM reads/writes and UART transfers
module instruction_sequencer
  import proc_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT,
  parameter int IRAM_LAT = 1,
  parameter int DRAM_LAT = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] iram_addr,
  input  logic [15:0]     iram_data,
  output logic [15:0]     ir,
  output logic [PC_W-1:0] pc,
  output logic            exec_en,
  input  logic            jmp_req,
  input  logic [PC_W-1:0] jmp_addr,
  input  logic            dram_we,
  input  logic            dram_wr_done,
  output logic            dram_re,
  output logic            mdr_load,
  input  logic            uart_start,
  input  logic            uart_done,
  output logic            halted,
  output logic            busy
);
  localparam int CW = $clog2(IRAM_LAT > DRAM_LAT ? IRAM_LAT : DRAM_LAT) + 1;
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0] opcode;
  logic [CW-1:0] cnt_val;
  logic cnt_load, cnt_zero;
  assign opcode = ir_q[15:12];
  assign iram_addr = pc_q;
  assign pc = pc_q;
  assign ir = ir_q;
  // strobes are gated by reset so nothing fires in the cycle reset is applied
  assign exec_en = rst_n && state_q == EXEC;
  assign dram_re = exec_en && opcode == OP_LOAD;
  assign mdr_load = rst_n && state_q == DRAM_RD && cnt_zero;
  assign halted = state_q == HALT;
  assign busy = state_q != IDLE && state_q != HALT;
  assign cnt_load = state_d != state_q;
  assign cnt_val = state_d == DRAM_RD ? CW'(DRAM_LAT - 1) : CW'(IRAM_LAT - 1);
  latency_counter #(.W(CW)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(cnt_load),
    .val_i (cnt_val),
    .zero_o(cnt_zero)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    case (state_q)
      IDLE:      state_d = start ? FETCH : IDLE;
      FETCH:     state_d = cnt_zero ? LOAD_IR : FETCH;
      LOAD_IR: begin
        ir_d = iram_data;
        pc_d = pc_q + PC_W'(1);
        state_d = EXEC;
      end
      EXEC: begin
        pc_d = jmp_req ? jmp_addr : pc_q;
        state_d = opcode == OP_HALT ? HALT :
                  opcode == OP_LOAD ? DRAM_RD :
                  dram_we ? DRAM_WR :
                  uart_start ? UART_WAIT : FETCH;
      end
      DRAM_RD:   state_d = cnt_zero ? FETCH : DRAM_RD;
      DRAM_WR:   state_d = dram_wr_done ? FETCH : DRAM_WR;
      UART_WAIT: state_d = uart_done ? FETCH : UART_WAIT;
      HALT:      state_d = HALT;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      ir_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  // the decoder never raises both a DRAM write and a UART transfer at once
  a_we_uart_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(state_q == EXEC && dram_we && uart_start));
endmodule
